// File: rtl/aes_pkg.sv
// Shared constants, FSM state encoding and word helpers for the AES block writeback stage.
package aes_pkg;

    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;

    localparam logic [3:0] WE_ALL  = 4'b1111;
    localparam logic [3:0] WE_NONE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wb_state_e;

    // Word 0 is the most significant word of the block.
    function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                     input logic [1:0]         idx);
        logic [WORD_W-1:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            2'd3:    w = blk[31:0];
            default: w = {WORD_W{1'b0}};
        endcase
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] byte_swap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_block_fifo.sv
// Synchronous block FIFO with 128-bit entries; push and pop in the same cycle is legal even when full.
module aes_block_fifo
    import aes_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic [BLOCK_W-1:0] push_data,
    input  logic               pop,
    output logic [BLOCK_W-1:0] head_data,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    logic [BLOCK_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Pointer and occupancy bookkeeping; flush empties the FIFO without touching storage.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (push_ok_s && !reset && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/aes_block_writeback.sv
// Serialises finished AES blocks into 32-bit output BRAM writes for one job at a time.
// Build option BLOCK_WB_BYTESWAP_EN byte-reverses every written word for little-endian hosts.
module aes_block_writeback
    import aes_pkg::*;
#(
    parameter int               ADDR_W     = 9,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  length,
    input  logic               blk_valid,
    input  logic [BLOCK_W-1:0] blk_data,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WORD_W-1:0]  mem_wdata,
    output logic [3:0]         mem_we,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic               fifo_full
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

    wb_state_e          state_r,    state_next_s;
    logic [ADDR_W-1:0]  len_r,      len_next_s;
    logic [ADDR_W-1:0]  word_cnt_r, cnt_next_s;
    logic [ADDR_W-1:0]  addr_cnt_r, addr_cnt_next_s;
    logic [1:0]         word_idx_r, idx_next_s;
    logic [ADDR_W-1:0]  mem_addr_r, addr_next_s;
    logic [WORD_W-1:0]  mem_wdata_r, wdata_next_s;
    logic [3:0]         mem_we_r,   we_next_s;
    logic               done_r,     done_next_s;
    logic               overflow_r, ovf_next_s;

    logic               flush_s;
    logic               pop_s;
    logic               push_req_s;
    logic               push_s;
    logic [ADDR_W-1:0]  cnt_inc_s;
    logic               last_s;
    logic [WORD_W-1:0]  out_word_s;
    logic [BLOCK_W-1:0] head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CNT_W-1:0]   fifo_count_s;

    aes_block_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_s),
        .push      (push_s),
        .push_data (blk_data),
        .pop       (pop_s),
        .head_data (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

`ifdef BLOCK_WB_BYTESWAP_EN
    assign out_word_s = byte_swap32(block_word(head_s, word_idx_r));
`else
    assign out_word_s = block_word(head_s, word_idx_r);
`endif

    assign cnt_inc_s = word_cnt_r + ONE_A;
    assign last_s    = (cnt_inc_s == len_r);

    // Next-state, write issue and FIFO control for the serialiser.
    always_comb begin
        state_next_s    = state_r;
        len_next_s      = len_r;
        cnt_next_s      = word_cnt_r;
        addr_cnt_next_s = addr_cnt_r;
        idx_next_s      = word_idx_r;
        addr_next_s     = mem_addr_r;
        wdata_next_s    = mem_wdata_r;
        we_next_s       = WE_NONE;
        done_next_s     = done_r;
        ovf_next_s      = overflow_r;
        flush_s         = 1'b0;
        pop_s           = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_next_s    = RUN;
                    len_next_s      = length;
                    cnt_next_s      = {ADDR_W{1'b0}};
                    addr_cnt_next_s = BASE_ADDR;
                    idx_next_s      = 2'd0;
                    addr_next_s     = BASE_ADDR;
                    done_next_s     = 1'b0;
                    ovf_next_s      = 1'b0;
                    flush_s         = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            RUN: begin
                if (word_cnt_r == len_r) begin
                    state_next_s = DONE;
                    done_next_s  = 1'b1;
                end else if (!fifo_empty_s) begin
                    we_next_s       = WE_ALL;
                    wdata_next_s    = out_word_s;
                    addr_next_s     = addr_cnt_r;
                    addr_cnt_next_s = addr_cnt_r + ONE_A;
                    cnt_next_s      = cnt_inc_s;
                    // A job ending mid-block drops the rest of that block.
                    pop_s           = (word_idx_r == 2'd3) || last_s;
                    idx_next_s      = pop_s ? 2'd0 : (word_idx_r + 2'd1);
                end else begin
                    we_next_s = WE_NONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        push_req_s = blk_valid && (state_r == RUN);
        push_s     = push_req_s && (!fifo_full_s || pop_s);
        if (push_req_s && !push_s) begin
            ovf_next_s = 1'b1;
        end else begin
            ovf_next_s = ovf_next_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            len_r       <= {ADDR_W{1'b0}};
            word_cnt_r  <= {ADDR_W{1'b0}};
            addr_cnt_r  <= BASE_ADDR;
            word_idx_r  <= 2'd0;
            mem_addr_r  <= BASE_ADDR;
            mem_wdata_r <= {WORD_W{1'b0}};
            mem_we_r    <= WE_NONE;
            done_r      <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            len_r       <= len_next_s;
            word_cnt_r  <= cnt_next_s;
            addr_cnt_r  <= addr_cnt_next_s;
            word_idx_r  <= idx_next_s;
            mem_addr_r  <= addr_next_s;
            mem_wdata_r <= wdata_next_s;
            mem_we_r    <= we_next_s;
            done_r      <= done_next_s;
            overflow_r  <= ovf_next_s;
        end
    end

    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_we    = mem_we_r;
    assign busy      = (state_r == RUN);
    assign done      = done_r;
    assign overflow  = overflow_r;
    assign fifo_full = (fifo_count_s == CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_aes_block_writeback.sv
// Directed self-checking bench for aes_block_writeback (default parameters).
module tb_aes_block_writeback;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [8:0]   length;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic [8:0]   mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_we;
    logic         busy;
    logic         done;
    logic         overflow;
    logic         fifo_full;

    aes_block_writeback dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .length    (length),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .fifo_full (fifo_full)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int done_cyc  = -1;
    bit full_seen = 1'b0;
    bit bad_we    = 1'b0;
    logic [8:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];

    function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef BLOCK_WB_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Word j of test block k is 32'hA500_0000 | k<<8 | j.
    function automatic logic [31:0] tw(input int k, input int j);
        return 32'hA500_0000 | (32'(k) << 8) | 32'(j);
    endfunction

    function automatic logic [127:0] tblk(input int k);
        return {tw(k, 0), tw(k, 1), tw(k, 2), tw(k, 3)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_we === 4'b1111) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wc_q.push_back(cyc);
        end else if (mem_we !== 4'b0000) begin
            bad_we = 1'b1;
        end
        if (fifo_full === 1'b1) full_seen = 1'b1;
        if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_cyc  = -1;
        full_seen = 1'b0;
    endtask

    task automatic do_start(input logic [8:0] len);
        start  = 1'b1;
        length = len;
        tick();
        start  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0; length = 9'd0; blk_valid = 1'b0; blk_data = 128'd0;
        tick(); tick();
        reset = 1'b0;
        total_cnt++;
        if ({mem_we, mem_addr, mem_wdata, busy, done, overflow, fifo_full} !== 50'd0)
            $display("FAIL reset_outputs got we=%b addr=%0d wd=%h busy=%b done=%b ovf=%b full=%b want all 0",
                     mem_we, mem_addr, mem_wdata, busy, done, overflow, fifo_full);
        else pass_cnt++;
    endtask

    task automatic test_single_block();
        int c0;
        clear_log();
        do_start(9'd4);
        c0 = cyc;
        blk_valid = 1'b1; blk_data = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        total_cnt++;
        if (wa_q.size() !== 4) $display("FAIL single_count got %0d want 4", wa_q.size());
        else pass_cnt++;
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            logic [31:0] w;
            case (i)
                0: w = 32'h00112233;
                1: w = 32'h44556677;
                2: w = 32'h8899AABB;
                default: w = 32'hCCDDEEFF;
            endcase
            total_cnt++;
            if (wa_q[i] !== 9'(i) || wd_q[i] !== exp_word(w) || wc_q[i] !== c0 + 2 + i)
                $display("FAIL single_word%0d got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                         i, wa_q[i], wd_q[i], wc_q[i], i, exp_word(w), c0 + 2 + i);
            else pass_cnt++;
        end
        total_cnt++;
        if (done_cyc !== c0 + 6 || overflow !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_done got done_cyc=%0d ovf=%b busy=%b want done_cyc=%0d ovf=0 busy=0",
                     done_cyc, overflow, busy, c0 + 6);
        else pass_cnt++;
    endtask

    task automatic test_zero_length();
        int cs;
        clear_log();
        cs = cyc;
        do_start(9'd0);
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b1)
            $display("FAIL zero_clear got done=%b busy=%b want done=0 busy=1", done, busy);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) tick();
        total_cnt++;
        if (done_cyc !== cs + 2 || wa_q.size() !== 0)
            $display("FAIL zero_len got done_cyc=%0d writes=%0d want done_cyc=%0d writes=0",
                     done_cyc, wa_q.size(), cs + 2);
        else pass_cnt++;
    endtask

    task automatic test_partial_block();
        clear_log();
        do_start(9'd6);
        blk_valid = 1'b1; blk_data = tblk(1);
        tick();
        blk_data = tblk(2);
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        total_cnt++;
        if (wa_q.size() !== 6) $display("FAIL partial_count got %0d want 6", wa_q.size());
        else pass_cnt++;
        for (int i = 0; i < 6 && i < wa_q.size(); i++) begin
            total_cnt++;
            if (wa_q[i] !== 9'(i) || wd_q[i] !== exp_word(tw(1 + i / 4, i % 4)))
                $display("FAIL partial_word%0d got addr=%0d data=%h want addr=%0d data=%h",
                         i, wa_q[i], wd_q[i], i, exp_word(tw(1 + i / 4, i % 4)));
            else pass_cnt++;
        end
        total_cnt++;
        if (done !== 1'b1 || fifo_full !== 1'b0 || busy !== 1'b0)
            $display("FAIL partial_done got done=%b full=%b busy=%b want 1 0 0", done, fifo_full, busy);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        int errs;
        clear_log();
        do_start(9'd64);
        for (int k = 1; k <= 6; k++) begin
            blk_valid = 1'b1; blk_data = tblk(k);
            tick();
        end
        blk_valid = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        total_cnt++;
        if (wa_q.size() !== 20) $display("FAIL ovf_count got %0d want 20", wa_q.size());
        else pass_cnt++;
        errs = 0;
        for (int i = 0; i < 20 && i < wa_q.size(); i++)
            if (wa_q[i] !== 9'(i) || wd_q[i] !== exp_word(tw(1 + i / 4, i % 4))) errs++;
        total_cnt++;
        if (errs !== 0) $display("FAIL ovf_order got %0d bad writes want 0", errs);
        else pass_cnt++;
        total_cnt++;
        if (overflow !== 1'b1 || full_seen !== 1'b1 || busy !== 1'b1)
            $display("FAIL ovf_flags got ovf=%b full_seen=%b busy=%b want 1 1 1", overflow, full_seen, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_midjob();
        int guard;
        clear_log();
        do_start(9'd4);
        blk_valid = 1'b1; blk_data = tblk(7);
        tick();
        blk_valid = 1'b0;
        guard = 0;
        while (wa_q.size() < 2 && guard < 20) begin
            tick();
            guard++;
        end
        total_cnt++;
        if (wa_q.size() !== 2) $display("FAIL midjob_reach got %0d writes want 2", wa_q.size());
        else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if ({mem_we, mem_addr, mem_wdata, busy, done, overflow, fifo_full} !== 50'd0)
            $display("FAIL midjob_reset got we=%b addr=%0d wd=%h busy=%b done=%b ovf=%b want all 0",
                     mem_we, mem_addr, mem_wdata, busy, done, overflow);
        else pass_cnt++;
        clear_log();
        for (int i = 0; i < 4; i++) tick();
        do_start(9'd4);
        blk_valid = 1'b1; blk_data = tblk(8);
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        total_cnt++;
        if (wa_q.size() !== 4 || wa_q[0] !== 9'd0 || wd_q[0] !== exp_word(tw(8, 0))
            || wa_q[3] !== 9'd3 || wd_q[3] !== exp_word(tw(8, 3)) || done !== 1'b1)
            $display("FAIL midjob_restart got writes=%0d done=%b want 4 writes from addr 0 block 8, done=1",
                     wa_q.size(), done);
        else pass_cnt++;
    endtask

    task automatic test_idle_discard();
        clear_log();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        blk_valid = 1'b1; blk_data = tblk(9);
        tick(); tick();
        blk_valid = 1'b0;
        do_start(9'd4);
        for (int i = 0; i < 4; i++) tick();
        // A start during RUN must be ignored.
        do_start(9'd0);
        for (int i = 0; i < 6; i++) tick();
        total_cnt++;
        if (wa_q.size() !== 0 || busy !== 1'b1 || overflow !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_discard got writes=%0d busy=%b ovf=%b done=%b want 0 1 0 0",
                     wa_q.size(), busy, overflow, done);
        else pass_cnt++;
        total_cnt++;
        if (bad_we !== 1'b0) $display("FAIL we_encoding got partial mem_we seen want only 0000/1111");
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_zero_length();
        test_partial_block();
        test_overflow();
        test_reset_midjob();
        test_idle_discard();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_block_writeback.md
Name: aes_block_writeback

Overview:
- Downstream stage of the AES round pipeline: captures each 128-bit result block as it leaves the last round and serialises it into 32-bit writes to the output BRAM port.
- Owns the output word-address counter, write enable, per-job word count and completion flag.
- The round pipeline cannot stall, so a small block FIFO absorbs bursts; loss is flagged, never back-pressured.

Parameters:
- ADDR_W, 9, width of output word address and length.
- FIFO_DEPTH, 4, block FIFO entries (power of 2, >=2).
- BASE_ADDR, 0, first output word address of every job.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  job start pulse; sampled every cycle.
- length  in  ADDR_W  words to write for this job (0..2^ADDR_W-1).
- blk_valid  in  1  blk_data holds a finished block this cycle.
- blk_data  in  128  result block; word 0 = bits 127:96.
- mem_addr  out  ADDR_W  output BRAM word address.
- mem_wdata  out  32  output BRAM write data.
- mem_we  out  4  byte write enables; 4'b1111 on a write, else 4'b0000.
- busy  out  1  job in progress.
- done  out  1  job complete; held until next start or reset.
- overflow  out  1  sticky: a block was dropped.
- fifo_full  out  1  FIFO holds FIFO_DEPTH blocks.

Behaviour:
- Synchronous, active-high reset: every output is 0, mem_addr = BASE_ADDR, FIFO empty, state IDLE. Reset mid-job abandons it with no further writes.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start: latch length, clear word count, overflow and done, flush FIFO, set mem_addr = BASE_ADDR, go RUN. If latched length = 0, go DONE on the next cycle with no writes.
- start while in RUN is ignored.
- blk_valid is accepted only in RUN. In IDLE/DONE it is discarded silently and overflow is not set.
- Push/pop:
  - push when not full;
  - push while full is allowed only if a pop happens the same cycle;
  - otherwise the block is dropped and overflow is set.
  - Push into an empty FIFO is not visible to the pop logic until the next cycle.
- RUN, FIFO non-empty: one word per cycle, word 0..3 of the head entry in order.
  - All outputs are registered: mem_we = 4'b1111, mem_wdata = word, mem_addr = current address.
  - Address and word count increment after each write. The address wraps modulo 2^ADDR_W.
  - Head entry is popped on the cycle word 3 is issued.
- Latency: blk_valid in cycle t into an empty FIFO produces the first mem_we in cycle t+2; the remaining three words follow back to back.
- Word count reaching length:
  - the last write is issued, then the state goes DONE next cycle with done = 1 and mem_we = 0;
  - any remaining words of a partial final block are discarded and the entry popped.
- Idle cycles: mem_we = 0. mem_wdata and mem_addr hold their last values.
- Status: busy = (state == RUN). fifo_full is combinational from the FIFO count.

Optional Feature:
- BLOCK_WB_BYTESWAP_EN defined: each 32-bit word is byte-reversed before being driven on mem_wdata (e.g. 32'h00112233 becomes 32'h33221100), for little-endian host reads.
- Not defined: words pass through unchanged.
- Addressing, ordering and timing are identical in both builds.

Decomposition:
- Shared package aes_pkg: block width 128, word width 32, WORDS_PER_BLOCK = 4, state encoding (IDLE = 0, RUN = 1, DONE = 2), WE_ALL = 4'b1111.
- One natural sub-module: aes_block_fifo. Synchronous FIFO with parameterised depth, 128-bit entries, push/pop/full/empty/count; a simultaneous push and pop while full is legal.
- Serialiser FSM, counters and output registers stay in the top.

Test Plan:
- start, length = 4, one block 0x00112233_44556677_8899AABB_CCDDEEFF → writes 00112233@0, 44556677@1, 8899AABB@2, CCDDEEFF@3 on 4 consecutive cycles; done = 1 the cycle after; overflow = 0.
- start, length = 0 → no mem_we; done = 1 two cycles after start.
- start, length = 6, two blocks → 6 writes to addresses 0..5; last two words of block 2 discarded; done = 1; FIFO empty.
- start, length = 64, 6 blocks on consecutive cycles with FIFO_DEPTH = 4 → exactly one block dropped, overflow = 1 sticky; fifo_full seen; surviving blocks written in order.
- Reset asserted after the 2nd write of a 4-word job → next cycle all outputs 0, mem_addr = 0; a new start restarts cleanly from address 0.
- blk_valid while IDLE, then start with length = 4 and no new block → no writes; busy stays 1; overflow = 0. With BLOCK_WB_BYTESWAP_EN, the first test's word 0 reads 33221100.
